// File: rtl/fp_host_pkg.sv
// Shared types and constants for the FP multiplier host-side initiator.
package fp_host_pkg;

  localparam int unsigned FP_W = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [3:0] {
    StIdle,
    StDrain,
    StXReq,
    StXRel,
    StYReq,
    StYRel,
    StRWait,
    StRAck,
    StDeliver
  } state_e;

endpackage

// File: rtl/fp_mult_host.sv
// Host initiator: sends x then y over the four-phase operand handshake, collects the product.
// Define FPHOST_TIMEOUT_EN to add a per-state watchdog that delivers a flagged qNaN.
module fp_mult_host
  import fp_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [FP_W-1:0] op_x,
  input  logic [FP_W-1:0] op_y,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [FP_W-1:0] res_data,
  output logic            res_err,
  output logic [FP_W-1:0] inBus,
  output logic            inReady,
  input  logic            inAccepted,
  input  logic [FP_W-1:0] outBus,
  input  logic            resultReady,
  output logic            resultAccepted,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [FP_W-1:0] inbus_q, inbus_d;
  logic [FP_W-1:0] y_q, y_d;
  logic [FP_W-1:0] res_q, res_d;

`ifdef FPHOST_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        counting;
  assign counting = (state_q != StIdle) && (state_q != StDeliver);
`endif

  always_comb begin
    state_d = state_q;
    inbus_d = inbus_q;
    y_d     = y_q;
    res_d   = res_q;
`ifdef FPHOST_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A leftover result must be cleared before any new pair is sent.
        if (resultReady) begin
          state_d = StDrain;
        end else if (op_valid) begin
          inbus_d = op_x;
          y_d     = op_y;
          state_d = StXReq;
        end
      end
      StDrain:   if (!resultReady) state_d = StIdle;
      StXReq:    if (inAccepted) state_d = StXRel;
      StXRel: begin
        if (!inAccepted) begin
          inbus_d = y_q;
          state_d = StYReq;
        end
      end
      StYReq:    if (inAccepted) state_d = StYRel;
      StYRel:    if (!inAccepted) state_d = StRWait;
      StRWait: begin
        if (resultReady) begin
          res_d   = outBus;
          state_d = StRAck;
        end
      end
      StRAck:    if (!resultReady) state_d = StDeliver;
      StDeliver: begin
        if (res_ready) begin
          state_d = StIdle;
`ifdef FPHOST_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default:   state_d = StIdle;
    endcase

`ifdef FPHOST_TIMEOUT_EN
    // Watchdog only fires when the state would otherwise stay put.
    if (counting && (state_d == state_q) && (cnt_q == TimeoutLast)) begin
      if (state_q == StDrain) begin
        state_d = StIdle;
      end else begin
        state_d = StDeliver;
        res_d   = FP_QNAN;
        err_d   = 1'b1;
      end
    end
    if (state_d != state_q) cnt_d = '0;
    else if (counting)      cnt_d = cnt_q + 16'd1;
    else                    cnt_d = cnt_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      inbus_q <= '0;
      y_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      inbus_q <= inbus_d;
      y_q     <= y_d;
      res_q   <= res_d;
    end
  end

`ifdef FPHOST_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

  assign op_ready       = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign inReady        = (state_q == StXReq) || (state_q == StYReq);
  assign resultAccepted = (state_q == StDrain) || (state_q == StRAck);
  assign res_valid      = (state_q == StDeliver);
  assign inBus          = inbus_q;
  assign res_data       = res_q;

endmodule
